// File: rtl/data_sram_responder_if.sv
// data_sram_responder_if: data-side SRAM-like req/addr_ok/data_ok bus between CPU (master) and responder (slave).
interface data_sram_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/data_sram_responder.sv
// data_sram_responder: word-array responder with fixed-latency in-order data_ok and bounded outstanding queue.
// Define DATA_SRAM_RANDOM_STALL_EN to add LFSR-driven addr_ok stalls.
module data_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2
) (
  input logic clk,
  input logic resetn,
  data_sram_responder_if.slave bus
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       q_data [DEPTH];
  logic [2:0]        q_cd [DEPTH];
  logic [DEPTH-1:0]  q_v;
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       word, merged;
  logic              rsp_now, stall, acc, unused;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
`ifdef DATA_SRAM_RANDOM_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk)
    lfsr <= !resetn ? 16'hACE1 : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign stall = lfsr[1:0] == 2'b00;
`else
  assign stall = 1'b0;
`endif
  assign unused       = ^{bus.size, bus.addr[31:ADDR_W+2], bus.addr[1:0]};
  assign idx          = bus.addr[ADDR_W+1:2];
  assign word         = mem[idx];
  assign rsp_now      = q_v[head] && q_cd[head] == '0;
  // resetn gates addr_ok so nothing is accepted while the queue is being cleared
  assign bus.addr_ok  = resetn && bus.req && !stall && ((count < CW'(DEPTH)) || rsp_now);
  assign acc          = bus.addr_ok;
  assign bus.data_ok  = rsp_now;
  assign bus.rdata    = rsp_now ? q_data[head] : '0;
  always_comb begin
    merged = word;
    for (int i = 0; i < 4; i++)
      if (bus.wr && bus.wstrb[i]) merged[8*i+:8] = bus.wdata[8*i+:8];
  end
  always_ff @(posedge clk)
    if (acc) mem[idx] <= merged;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      q_v   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (q_v[i] && q_cd[i] != '0) q_cd[i] <= q_cd[i] - 3'd1;
      if (rsp_now) begin
        q_v[head] <= 1'b0;
        head      <= nxt(head);
      end
      if (acc) begin
        q_v[tail]    <= 1'b1;
        q_cd[tail]   <= 3'(LATENCY - 1);
        q_data[tail] <= bus.wr ? '0 : word;
        tail         <= nxt(tail);
      end
      if (acc && !rsp_now) count <= count + CW'(1);
      else if (rsp_now && !acc) count <= count - CW'(1);
    end
  end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: directed and model-checked stimulus for data_sram_responder (L=2/D=2 and L=3/D=2 instances).
module tb_data_sram_responder;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  data_sram_responder_if a ();
  data_sram_responder_if b ();
  data_sram_responder #(.ADDR_W(10), .LATENCY(2), .DEPTH(2)) dut_a (.clk(clk), .resetn(resetn), .bus(a));
  data_sram_responder #(.ADDR_W(10), .LATENCY(3), .DEPTH(2)) dut_b (.clk(clk), .resetn(resetn), .bus(b));
  typedef struct {logic [31:0] d; int due;} exp_t;
  exp_t        q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] exp_rd [9];
  logic [8:0]  exp_aok_b = 9'b000011011;
  logic [8:0]  exp_dok_b = 9'b011011000;
  logic [31:0] addr, d;
  logic        wr, exp_ok, exp_aok, acc_last;
  int passed = 0, total = 0;
  int ops, cyc, stalls, occ, k, w, n_ops;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive_a(input logic req, input logic w_, input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] st);
    a.req = req; a.wr = w_; a.addr = ad; a.wdata = wd; a.wstrb = st; a.size = 2'd2;
  endtask
  task automatic drive_b(input logic req, input logic w_, input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] st);
    b.req = req; b.wr = w_; b.addr = ad; b.wdata = wd; b.wstrb = st; b.size = 2'd2;
  endtask
  initial begin
    exp_rd = '{32'h0, 32'h0, 32'h0, 32'hA0, 32'hA1, 32'h0, 32'hA2, 32'hA3, 32'h0};
    drive_a(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_b(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) begin
      tick; #1;
      chk("rst_aok_a", a.addr_ok, 0);
      chk("rst_dok_a", a.data_ok, 0);
      chk("rst_rd_a", a.rdata, 0);
      chk("rst_aok_b", b.addr_ok, 0);
    end
    tick;
    resetn = 1'b1;
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_b(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
`ifndef DATA_SRAM_RANDOM_STALL_EN
    // store then load same word, latency 2
    tick; drive_a(1'b1, 1'b1, 32'h1000_0004, 32'hDEADBEEF, 4'hF); #1;
    chk("st_aok", a.addr_ok, 1);
    tick; drive_a(1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'h0); #1;
    chk("ld_aok", a.addr_ok, 1);
    chk("ld_dok_early", a.data_ok, 0);
    tick; drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    chk("st_dok", a.data_ok, 1);
    chk("st_rd", a.rdata, 0);
    tick; #1;
    chk("ld_dok", a.data_ok, 1);
    chk("ld_rd", a.rdata, 32'hDEADBEEF);
    tick; #1;
    chk("idle_dok", a.data_ok, 0);
    // byte-lane merge, slot reuse on full, address aliasing
    tick; drive_a(1'b1, 1'b1, 32'h0000_0008, 32'h11223344, 4'hF); #1;
    tick; drive_a(1'b1, 1'b1, 32'h0000_0008, 32'h00005A00, 4'b0010); #1;
    tick; drive_a(1'b1, 1'b0, 32'h0000_0008, 32'hFFFF_FFFF, 4'hF); #1;
    chk("reuse_aok", a.addr_ok, 1);
    chk("st1_dok", a.data_ok, 1);
    tick; drive_a(1'b1, 1'b0, 32'h7000_100A, 32'h0, 4'h0); #1;
    chk("alias_aok", a.addr_ok, 1);
    chk("st2_rd", a.rdata, 0);
    tick; drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    chk("merge_dok", a.data_ok, 1);
    chk("merge_rd", a.rdata, 32'h11225A44);
    tick; #1;
    chk("alias_rd", a.rdata, 32'h11225A44);
    tick; #1;
    chk("merge_idle", a.data_ok, 0);
    // reset with two responses outstanding
    for (int c = 0; c < 4; c++) begin
      tick; drive_a(1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0); #1;
      chk("pre_aok", a.addr_ok, 1);
      if (c >= 2) chk("pre_rd", a.rdata, 32'h11225A44);
    end
    tick; resetn = 1'b0; #1;
    chk("rst_pulse_aok", a.addr_ok, 0);
    tick; resetn = 1'b1; drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    chk("post_rst_dok0", a.data_ok, 0);
    tick; #1;
    chk("post_rst_dok1", a.data_ok, 0);
    tick; drive_a(1'b1, 1'b1, 32'h0000_000C, 32'h1, 4'hF); #1;
    chk("post_rst_aok", a.addr_ok, 1);
    tick; drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    chk("post_rst_t1", a.data_ok, 0);
    tick; #1;
    chk("post_rst_t2", a.data_ok, 1);
    chk("post_rst_rd", a.rdata, 0);
    tick; #1;
    chk("post_rst_t3", a.data_ok, 0);
    // latency 3, depth 2: preload then hold req for six cycles
    for (int j = 0; j < 4; j++) begin
      tick; drive_b(1'b1, 1'b1, 32'(j * 4), 32'hA0 + 32'(j), 4'hF); #1;
      w = 0;
      while (!b.addr_ok && w < 20) begin tick; #1; w++; end
      chk("b_pre_aok", b.addr_ok, 1);
    end
    tick; drive_b(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (6) tick;
    k = 0;
    for (int c = 0; c < 9; c++) begin
      tick; drive_b(c < 6, 1'b0, 32'(k * 4), 32'h0, 4'h0); #1;
      chk($sformatf("b_aok%0d", c), b.addr_ok, exp_aok_b[c]);
      chk($sformatf("b_dok%0d", c), b.data_ok, exp_dok_b[c]);
      chk($sformatf("b_rd%0d", c), b.rdata, exp_rd[c]);
      if (b.req && b.addr_ok) k++;
    end
`endif
    // random loads/stores against a reference array
`ifdef DATA_SRAM_RANDOM_STALL_EN
    n_ops = 1000;
`else
    n_ops = 300;
`endif
    ops = 0; cyc = 0; stalls = 0; acc_last = 1'b0;
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    while ((ops < n_ops || q.size() > 0) && cyc < 20000) begin
      tick; cyc++;
      if (acc_last) a.req = 1'b0;
      acc_last = 1'b0;
      if (!a.req && ops < n_ops && $urandom_range(3) != 0) begin
        wr   = (ops < 16) || ($urandom_range(1) == 1);
        addr = ops < 16 ? 32'(ops * 4) : ($urandom & 32'hFFFF_F03F);
        drive_a(1'b1, wr, addr, $urandom, ops < 16 ? 4'hF : 4'($urandom));
      end
      #1;
      occ    = q.size();
      exp_ok = occ > 0 && q[0].due == cyc;
      chk("rnd_dok", a.data_ok, exp_ok);
      if (exp_ok) begin
        chk("rnd_rd", a.rdata, q[0].d);
        void'(q.pop_front());
      end
      exp_aok = a.req && (occ < 2 || exp_ok);
`ifdef DATA_SRAM_RANDOM_STALL_EN
      chk("rnd_aok", a.addr_ok & ~exp_aok, 0);
      if (a.req && !a.addr_ok && occ < 2) stalls++;
`else
      chk("rnd_aok", a.addr_ok, exp_aok);
`endif
      if (a.req && a.addr_ok) begin
        d = a.wr ? 32'h0 : ref_mem[a.addr[5:2]];
        if (a.wr)
          for (int i = 0; i < 4; i++)
            if (a.wstrb[i]) ref_mem[a.addr[5:2]][8*i+:8] = a.wdata[8*i+:8];
        q.push_back('{d, cyc + 2});
        ops++;
        acc_last = 1'b1;
      end
    end
    chk("rnd_done", ops == n_ops && q.size() == 0, 1);
`ifdef DATA_SRAM_RANDOM_STALL_EN
    chk("stall_seen", stalls > 0, 1);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Slave (responder) end of the data-side SRAM-like interface (req/addr_ok/data_ok) driven by the CPU's EX/MEM stages.
- Accepts load/store requests, applies them to an internal word array and returns in-order responses after a fixed latency.
- Serves as the bench/SoC-lite model for exercising the MEM stage's data_ok buffering and abandon logic.

Parameters:
- ADDR_W, 10: word-index width; array depth 2^ADDR_W 32-bit words.
- LATENCY, 2: cycles from request acceptance to data_ok; legal range 1..8.
- DEPTH, 2: maximum outstanding (accepted, not yet responded) requests; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- data_sram_req  in  1  request valid.
- data_sram_wr  in  1  1 = store, 0 = load.
- data_sram_size  in  2  0 = byte, 1 = half, 2 = word; informational, wstrb is authoritative.
- data_sram_wstrb  in  4  byte write enables for stores.
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  store data.
- data_sram_addr_ok  out  1  request accepted this cycle when high together with req.
- data_sram_data_ok  out  1  one-cycle response pulse.
- data_sram_rdata  out  32  load data, valid while data_ok is high.

Behaviour:
- Reset (resetn = 0 at a clock edge):
  - pending count = 0; all queue entries invalid.
  - data_ok = 0, rdata = 0.
  - Array contents are not cleared.
  - A reset mid-operation drops every outstanding response; no data_ok follows.
- Acceptance:
  - acc = req & addr_ok.
  - addr_ok = req & ((count < DEPTH) | rsp_now), where rsp_now is this cycle's data_ok. A freed slot is reusable in the same cycle.
  - addr_ok is low whenever req is low.
  - At most one acceptance per cycle.
- Array access at acceptance:
  - Word index = addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 are ignored, so upper addresses alias.
  - Store: byte lane i is written with wdata[8i+7:8i] when wstrb[i] = 1.
  - Load: reads the whole word as it stands after all earlier accepted stores. A read of the same word in the cycle after a store returns the stored data.
  - Load and store use the same path; wstrb on loads is ignored.
- Queue:
  - Circular FIFO of DEPTH entries; each entry holds {data[31:0], is_wr, countdown}.
  - On acceptance an entry is pushed with countdown = LATENCY-1.
  - Each cycle every valid entry with countdown > 0 decrements.
- Response:
  - data_ok = 1 in the cycle the head entry is valid with countdown = 0; head pops in that cycle.
  - Net effect: a request accepted at edge T produces data_ok during cycle T+LATENCY.
  - rdata = word read at acceptance for loads, 32'h0 for stores. Loads return the full word; sub-word extraction is the requester's job.
  - Responses return strictly in acceptance order, at most one per cycle.
- Counters:
  - count increments on acc & ~rsp_now, decrements on rsp_now & ~acc, and holds when both or neither occur.
  - Push and pop pointers wrap modulo DEPTH; count never exceeds DEPTH.
- Full/throughput:
  - With DEPTH >= LATENCY, back-to-back acceptance is sustained at one per cycle.
  - With DEPTH < LATENCY, addr_ok deasserts while count = DEPTH and no response is due.
- data_ok is never held or retried: the requester must capture it. No backpressure input exists.
- A req that stays high while addr_ok is low must not cause any array or queue change.

Optional Feature:
- Macro: DATA_SRAM_RANDOM_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - addr_ok is additionally forced low whenever lfsr[1:0] == 2'b00, which exercises requester hold behaviour.
  - Latency and ordering are unchanged.
- Undefined: no LFSR; addr_ok depends only on req and occupancy, as specified above.

Test Plan:
- Reset held 3 cycles with req = 1 → addr_ok = 0, data_ok = 0, rdata = 0 throughout.
- Store addr 0x1000_0004, wdata 0xDEADBEEF, wstrb 4'hF, then load the same addr next cycle (LATENCY = 2) → data_ok pulses for the store (rdata 0), then the next cycle for the load (rdata 0xDEADBEEF).
- Store wstrb 4'b0010, wdata 0x0000_5A00 over word 0x11223344, then load → rdata 0x11225A44.
- LATENCY = 3, DEPTH = 2, req held high 6 cycles → addr_ok pattern 1,1,0,1,1,0; responses in order, never two in one cycle.
- 4 requests accepted, resetn pulsed low 1 cycle while 2 are outstanding → no data_ok after reset; first post-reset request responds at exactly T+LATENCY.
- With DATA_SRAM_RANDOM_STALL_EN defined, 1000 random loads/stores vs a reference array → all rdata match; at least one cycle with req = 1 and addr_ok = 0 while count < DEPTH.
